// File: rtl/zld_fsm_dp.sv
// -----------------------------------------------------------------------------
// zld_fsm_dp -- zero run-length decoder
//
// Expands the token stream from the zero run-length encoder into the original
// data stream. A literal token (MSB=0) produces one data word. A run token
// (MSB=1) produces i_d[RUNW-1:0]+1 zero words. The FSM, the literal register
// and the run counter all live in this one block.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous, active-low reset
//   i_v     in   input token valid
//   i_d     in   input token [W-1:0]
//   i_b     out  input busy; a token transfers when i_v=1 and i_b=0
//   o_v     out  output data valid
//   o_d     out  output data word [W-1:0]
//   o_b     in   output busy; a word transfers when o_v=1 and o_b=0
//   stateo  out  current FSM state, for monitoring
// -----------------------------------------------------------------------------
module zld_fsm_dp #(
    parameter int W    = 16,
    parameter int RUNW = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_v,
    input  logic [W-1:0] i_d,
    output logic         i_b,
    output logic         o_v,
    output logic [W-1:0] o_d,
    input  logic         o_b,
    output logic [1:0]   stateo
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LIT   = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    lit_q;
    logic [RUNW-1:0] cnt_q;
    logic            take;

    // Outputs are decoded from the current state. i_b drops in LIT/RUN only
    // when the word leaving this cycle is the last word of its token, so the
    // next token can be fetched in the same cycle (o_b -> i_b is a
    // deliberate combinational path). Reset forces i_b high so nothing is
    // consumed while the block is held in reset.
    always_comb begin
        o_v = 1'b0;
        o_d = '0;
        i_b = 1'b1;
        if (reset) begin
            case (state)
                FETCH: i_b = 1'b0;
                LIT: begin
                    o_v = 1'b1;
                    o_d = lit_q;
                    i_b = o_b;
                end
                RUN: begin
                    o_v = 1'b1;
                    i_b = o_b || (cnt_q != '0);
                end
                default: i_b = 1'b1;
            endcase
        end
    end

    assign take   = i_v && !i_b;
    assign stateo = state;

    // A taken token always overrides the state's own advance: take can only
    // be high in FETCH or when the final word of the current token is
    // leaving, so loading the new token is exactly the right next step.
    // cnt_q holds remaining zeros minus one and only decrements while
    // nonzero, so it can never wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            lit_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            if (i_d[W-1]) begin
                cnt_q <= i_d[RUNW-1:0];
                state <= RUN;
            end else begin
                lit_q <= {1'b0, i_d[W-2:0]};
                state <= LIT;
            end
        end else begin
            case (state)
                FETCH: state <= FETCH;
                LIT: begin
                    if (!o_b) begin
                        state <= FETCH;
                    end
                end
                RUN: begin
                    if (!o_b) begin
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
